// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with per-grant hold limit.
// Ports: HCLK, HRESET (sync, active-high), HBUSREQ/HLOCK per master,
//   HTRANS, HREADY in; HGRANT (one-hot), HMASTER, HMASTLOCK out.
// Optional locked transfers: define AHB_ARB_LOCK_EN.
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_HOLD       = 16
) (
   input  logic                           HCLK,
   input  logic                           HRESET,
   input  logic [NUM_MASTERS-1:0]         HBUSREQ,
   input  logic [NUM_MASTERS-1:0]         HLOCK,
   input  logic [1:0]                     HTRANS,
   input  logic                           HREADY,
   output logic [NUM_MASTERS-1:0]         HGRANT,
   output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
   output logic                           HMASTLOCK
);

   localparam int MW = $clog2(NUM_MASTERS);
   localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   localparam logic [MW-1:0] DEF_IDX  = MW'(DEFAULT_MASTER);
   localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
   localparam logic [1:0]    SEQ      = 2'b11;

   localparam logic [NUM_MASTERS-1:0] DEF_GNT =
      NUM_MASTERS'(1) << DEFAULT_MASTER;

   typedef enum logic [1:0] {
      S_PARK   = 2'd0,
      S_OWNED  = 2'd1
`ifdef AHB_ARB_LOCK_EN
      ,
      S_LOCKED = 2'd2
`endif
   } state_t;

   state_t                 state_q, state_d;
   logic [MW-1:0]          owner_q, owner_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
   logic [MW-1:0]          mst_q;
   logic                   others;
   logic                   own_req;
   logic                   expired;

`ifdef AHB_ARB_LOCK_EN
   logic                   mlock_q;
`else
   logic                   unused_lock;
   assign unused_lock = ^HLOCK;
`endif

   // First requester after base, wrapping; base itself is tried last
   // so a lone owner re-wins its own grant at expiry.
   function automatic logic [MW-1:0] rr_pick(
      input logic [NUM_MASTERS-1:0] req,
      input logic [MW-1:0]          base
   );
      logic [MW:0] idx;
      logic        found;
      rr_pick = base;
      found   = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx = {1'b0, base} + (MW+1)'(k);
         if (idx >= (MW+1)'(NUM_MASTERS))
            idx = idx - (MW+1)'(NUM_MASTERS);
         if (!found && req[idx[MW-1:0]]) begin
            rr_pick = idx[MW-1:0];
            found   = 1'b1;
         end
      end
   endfunction

   // State register; HREADY low freezes all arbitration state.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_PARK;
         owner_q <= DEF_IDX;
         grant_q <= DEF_GNT;
         cnt_q   <= '0;
         mst_q   <= DEF_IDX;
`ifdef AHB_ARB_LOCK_EN
         mlock_q <= 1'b0;
`endif
      end else if (HREADY) begin
         state_q <= state_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         // address phase follows the grant that was on the bus
         mst_q   <= owner_q;
`ifdef AHB_ARB_LOCK_EN
         mlock_q <= HLOCK[owner_q];
`endif
      end
   end

   // Next-state logic, evaluated for a HREADY-high edge.
   always_comb begin
      others  = |(HBUSREQ & ~grant_q);
      own_req = HBUSREQ[owner_q];
      expired = (MAX_HOLD != 0) && (cnt_q == HOLD_MAX)
                && (HTRANS != SEQ);

      cnt_inc = cnt_q;
      if (state_q == S_OWNED && others && MAX_HOLD != 0
          && cnt_q != HOLD_MAX)
         cnt_inc = cnt_q + 1'b1;

      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;

`ifdef AHB_ARB_LOCK_EN
      if (state_q == S_LOCKED) begin
         if (!HLOCK[owner_q])
            state_d = S_OWNED;
      end else if (state_q == S_OWNED && own_req
                   && HLOCK[owner_q]) begin
         state_d = S_LOCKED;
         cnt_d   = cnt_inc;
      end else
`endif
      if (!own_req || expired) begin
         cnt_d = '0;
         if (|HBUSREQ) begin
            owner_d = rr_pick(HBUSREQ, owner_q);
            state_d = S_OWNED;
         end else begin
            owner_d = DEF_IDX;
            state_d = S_PARK;
         end
      end else begin
         state_d = S_OWNED;
         cnt_d   = cnt_inc;
      end

      grant_d          = '0;
      grant_d[owner_d] = 1'b1;
   end

   // Outputs straight from registers.
   always_comb begin
      HGRANT  = grant_q;
      HMASTER = mst_q;
`ifdef AHB_ARB_LOCK_EN
      HMASTLOCK = mlock_q;
`else
      HMASTLOCK = 1'b0;
`endif
   end

endmodule
